// File: rtl/lynx_ram_arbiter.sv
// Shares one ssdram port between Lynx video fetch and Z80 CPU; video has priority.
// Define LYNX_RAM_ARB_FAIR_EN to alternate grants when both ports are waiting.
module lynx_ram_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 8,
  parameter int ACC_CYCLES = 6
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic          vid_ack_o,
  output logic [DW-1:0] vid_data_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_data_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          ram_cs_o,
  output logic          ram_oe_o,
  output logic          ram_we_o,
  output logic          busy_o
);

  if ((ACC_CYCLES < 2) || (ACC_CYCLES > 15)) begin : g_bad_acc_cycles
    $error("lynx_ram_arbiter: ACC_CYCLES must be within 2..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

  state_t        state_q, state_d;
  logic          owner_cpu_q, owner_cpu_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic [DW-1:0] cpu_data_q, cpu_data_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          busy_q, busy_d;
  logic          grant_cpu;

`ifdef LYNX_RAM_ARB_FAIR_EN
  logic last_vid_q, last_vid_d;

  // After a video grant the CPU wins any tie, so neither side is granted twice while the other waits
  assign grant_cpu = cpu_req_i & (~vid_req_i | last_vid_q);
`else
  assign grant_cpu = cpu_req_i & ~vid_req_i;
`endif

  always_comb begin
    state_d     = state_q;
    owner_cpu_d = owner_cpu_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vid_data_d  = vid_data_q;
    cpu_data_d  = cpu_data_q;
    cnt_d       = cnt_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
`ifdef LYNX_RAM_ARB_FAIR_EN
    last_vid_d  = last_vid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (vid_req_i || cpu_req_i) begin
          owner_cpu_d = grant_cpu;
          we_d        = grant_cpu & cpu_we_i;
          addr_d      = grant_cpu ? cpu_addr_i : vid_addr_i;
          if (grant_cpu) begin
            wdata_d = cpu_data_i;
          end
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (owner_cpu_q) begin
            cpu_ack_d = 1'b1;
            if (!we_q) begin
              cpu_data_d = ram_data_i;
            end
          end else begin
            vid_ack_d  = 1'b1;
            vid_data_d = ram_data_i;
          end
`ifdef LYNX_RAM_ARB_FAIR_EN
          last_vid_d = ~owner_cpu_q;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      owner_cpu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_data_q  <= '0;
      cpu_data_q  <= '0;
      cnt_q       <= 4'd0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_cpu_q <= owner_cpu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vid_data_q  <= vid_data_d;
      cpu_data_q  <= cpu_data_d;
      cnt_q       <= cnt_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      busy_q      <= busy_d;
    end
  end

`ifdef LYNX_RAM_ARB_FAIR_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_vid_q <= 1'b0;
    end else begin
      last_vid_q <= last_vid_d;
    end
  end
`endif

  // Strobes come straight from the state flop so an async reset drops them without a clock edge
  assign ram_cs_o   = (state_q == ACCESS);
  assign ram_oe_o   = ram_cs_o & ~we_q;
  assign ram_we_o   = ram_cs_o & we_q;
  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;
  assign vid_ack_o  = vid_ack_q;
  assign cpu_ack_o  = cpu_ack_q;
  assign vid_data_o = vid_data_q;
  assign cpu_data_o = cpu_data_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/lynx_ram_arbiter.md
# lynx_ram_arbiter

Two-port arbiter that shares the single `ssdram` controller port between the Lynx video fetch and the Z80 CPU. Each requester uses a request/acknowledge handshake. The arbiter sequences one SDRAM access at a time by driving the controller's `addr_i`/`data_i`/`cs_i`/`oe_i`/`we_i` and sampling its `data_o`. It sits between the `lynx48` core and `ssdram`, in the `clk_sdram` domain.

## Interface
Parameters:
- AW, 24: address width, matching the `ssdram` address port.
- DW, 8: data width.
- ACC_CYCLES, 6: cycles `ram_cs_o` is held per access. Legal range is 2..15.

Ports:
- clock_i  in  1  SDRAM-domain clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- vid_req_i  in  1  video read request. Level signal, held until ack.
- vid_addr_i  in  AW  video read address. Must be stable while `vid_req_i` is high.
- vid_ack_o  out  1  one-cycle pulse: video access complete.
- vid_data_o  out  DW  video read data. Valid with `vid_ack_o`, held until the next video ack.
- cpu_req_i  in  1  CPU request. Level signal, held until ack.
- cpu_we_i  in  1  1 = write, 0 = read. Stable while `cpu_req_i` is high.
- cpu_addr_i  in  AW  CPU address.
- cpu_data_i  in  DW  CPU write data.
- cpu_ack_o  out  1  one-cycle pulse: CPU access complete.
- cpu_data_o  out  DW  CPU read data. Valid with `cpu_ack_o`, held until the next CPU read ack.
- ram_addr_o  out  AW  to `ssdram` `addr_i`.
- ram_data_o  out  DW  to `ssdram` `data_i`.
- ram_data_i  in  DW  from `ssdram` `data_o`.
- ram_cs_o  out  1  to `cs_i`.
- ram_oe_o  out  1  to `oe_i`.
- ram_we_o  out  1  to `we_i`.
- busy_o  out  1  high whenever the arbiter is not in IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled on each clock edge.
  - If any request is pending, latch the owner (VID or CPU), the address, the direction and the write data, then go to ACCESS.
  - Arbitration is strict video priority: when both requests are high in the same cycle, VID wins (see Configuration for the fairness exception).
- ACCESS:
  - `ram_cs_o` is 1.
  - `ram_oe_o` = ~we_latched and `ram_we_o` = we_latched. VID is always a read.
  - The address and data outputs are driven from the latches, not from the requester inputs.
  - An internal counter counts ACC_CYCLES cycles, 0 to ACC_CYCLES-1.
  - On the edge that ends the last ACCESS cycle, `ram_data_i` is captured into the owner's data register (reads only), then go to DONE.
  - A CPU write leaves `cpu_data_o` unchanged.
- DONE:
  - For one cycle, `ram_cs_o`/`ram_oe_o`/`ram_we_o` are 0 and the owner's ack is 1. Then go to IDLE.
- Requester rule: the requester deasserts req on the clock edge at which it samples ack=1. A req still high in IDLE is treated as a new request.
- Requests arriving during ACCESS or DONE wait. They are never lost, because they are level-held.
- Counter width is 4 bits. ACC_CYCLES outside 2..15 is a configuration error (elaboration assertion).

## Timing
- Reset (async assert, sync release):
  - state = IDLE, all acks = 0, cs/oe/we = 0.
  - `ram_addr_o`, `ram_data_o`, `vid_data_o` and `cpu_data_o` = 0.
  - `busy_o` = 0.
- Reset asserted mid-ACCESS: the access is abandoned, no ack is issued, and outputs go to their reset values immediately.
- Latency: a request sampled in IDLE at edge e0 produces ack high during cycle e0+ACC_CYCLES+1. With the default, the ack arrives in the 7th cycle after sampling.
- Back-to-back throughput: one access per ACC_CYCLES+2 cycles (IDLE + ACCESS + DONE). The default gives 8 cycles per access.
- Ack outputs are registered. Data outputs are updated on the same edge that raises the ack.
- `busy_o` is registered and is high in ACCESS and DONE.

## Configuration
- Macro: LYNX_RAM_ARB_FAIR_EN.
- Defined: add a `last_vid` flag, set when a VID access completes and cleared when a CPU access completes. In IDLE, when both requests are pending and `last_vid` = 1, the CPU wins. Neither port can then be granted twice in a row while the other waits.
- Undefined: strict video priority; the CPU may starve while `vid_req_i` stays high.

## Test plan
- Lone CPU write: addr 0x001234, data 0xA5, ACC_CYCLES=6 -> `ram_cs_o` and `ram_we_o` high for exactly 6 cycles with `ram_addr_o` = 0x001234 and `ram_data_o` = 0xA5; `cpu_ack_o` pulses once, 7 cycles after sampling.
- CPU read: `ram_data_i` = 0x3C during the last ACCESS cycle -> `cpu_data_o` = 0x3C with the ack and held afterwards; `vid_data_o` unchanged.
- Simultaneous requests, both held for 3 accesses each:
  - Without the macro: grant order VID, VID, VID, CPU, CPU, CPU.
  - With LYNX_RAM_ARB_FAIR_EN: VID, CPU, VID, CPU, VID, CPU.
- Request changes its inputs mid-ACCESS (`cpu_addr_i` changed from 0x10 to 0x20) -> `ram_addr_o` stays 0x10 until DONE.
- Reset asserted in the 3rd ACCESS cycle -> cs/oe/we = 0 in the same cycle with no clock edge needed; no ack issued; after release, a held request is re-granted from IDLE.
- Requester keeps req high one cycle past the ack -> a second access is started and acked, confirming the level-request rule.
